ls_input_conditioner: RTL and testbench

//  Upstream stage of the low-speed input PIO. Synchronises WIDTH asynchronous raw lines, debounces each

---
 rtl/ls_input_pkg.sv | 12 +
 rtl/ls_debounce_bit.sv | 46 ++++
 rtl/ls_input_conditioner.sv | 124 ++++++++++++
 tb/tb_ls_input_conditioner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ls_input_pkg.sv
// Shared constants for the low-speed input conditioner: register word addresses
// and the width of the optional stable-edge counter (LS_COND_CHANGE_CNT_EN).
package ls_input_pkg;

  localparam logic [1:0] LS_REG_DATA = 2'd0;
  localparam logic [1:0] LS_REG_THR  = 2'd1;
  localparam logic [1:0] LS_REG_INV  = 2'd2;
  localparam logic [1:0] LS_REG_BYP  = 2'd3;

  localparam int LS_CC_W = 16;

endpackage

// File: rtl/ls_debounce_bit.sv
// One input line: synchroniser chain, stability counter and debounced level.
// The counter is bounded by thr_eff-1, so it never wraps.
module ls_debounce_bit #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_raw,
  input  logic [CNT_W-1:0] i_thr_eff,
  output logic             o_sync,
  output logic             o_stable
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic [CNT_W-1:0]       w_limit;
  logic                   w_sync;

  // i_thr_eff is never zero, so the limit cannot underflow
  assign w_limit = i_thr_eff - CNT_W'(1);
  assign w_sync  = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= w_limit) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync   = w_sync;
  assign o_stable = r_stable;

endmodule

// File: rtl/ls_input_conditioner.sv
// Synchronise, debounce, invert/bypass WIDTH raw lines behind a 4-word Avalon-MM slave.
// Define LS_COND_CHANGE_CNT_EN to add the saturating stable-change counter at addr 0 [31:16].
module ls_input_conditioner
  import ls_input_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CNT_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEF_DEBOUNCE = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] clean_out
);

  localparam logic [CNT_W-1:0] DEF_THR = CNT_W'(DEF_DEBOUNCE);

  logic               w_wr;
  logic [CNT_W-1:0]   r_thr;
  logic [CNT_W-1:0]   w_thr_eff;
  logic [WIDTH-1:0]   r_inv;
  logic [WIDTH-1:0]   r_byp;
  logic [WIDTH-1:0]   w_sync;
  logic [WIDTH-1:0]   w_stable;
  logic [WIDTH-1:0]   r_clean;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;
  logic [LS_CC_W-1:0] w_change_cnt;
  logic               w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_thr_eff = (r_thr == '0) ? CNT_W'(1) : r_thr;
  assign w_unused  = ^writedata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ls_debounce_bit #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_raw     (raw_in[gi]),
      .i_thr_eff (w_thr_eff),
      .o_sync    (w_sync[gi]),
      .o_stable  (w_stable[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thr <= DEF_THR;
      r_inv <= '0;
      r_byp <= '0;
    end else if (w_wr) begin
      case (address)
        LS_REG_THR: r_thr <= writedata[CNT_W-1:0];
        LS_REG_INV: r_inv <= writedata[WIDTH-1:0];
        LS_REG_BYP: r_byp <= writedata[WIDTH-1:0];
        default:    ;
      endcase
    end
  end

`ifdef LS_COND_CHANGE_CNT_EN
  logic [LS_CC_W-1:0] r_change_cnt;
  logic [WIDTH-1:0]   r_stable_prev;
  logic               w_any_change;

  // Edges are seen one cycle late against the delayed copy; a clear wins over an increment
  assign w_any_change = |(w_stable ^ r_stable_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_prev <= '0;
      r_change_cnt  <= '0;
    end else begin
      r_stable_prev <= w_stable;
      if (w_wr && (address == LS_REG_DATA)) begin
        r_change_cnt <= '0;
      end else if (w_any_change && (r_change_cnt != '1)) begin
        r_change_cnt <= r_change_cnt + LS_CC_W'(1);
      end
    end
  end

  assign w_change_cnt = r_change_cnt;
`else
  assign w_change_cnt = '0;
`endif

  always_comb begin
    w_rdata = 32'd0;
    case (address)
      LS_REG_DATA: begin
        w_rdata[WIDTH-1:0] = r_clean;
        w_rdata[31:16]     = w_change_cnt;
      end
      LS_REG_THR: w_rdata[CNT_W-1:0] = r_thr;
      LS_REG_INV: w_rdata[WIDTH-1:0] = r_inv;
      LS_REG_BYP: w_rdata[WIDTH-1:0] = r_byp;
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clean <= '0;
      r_rdata <= 32'd0;
    end else begin
      r_clean <= ((r_byp & w_sync) | (~r_byp & w_stable)) ^ r_inv;
      r_rdata <= w_rdata;
    end
  end

  assign clean_out = r_clean;
  assign readdata  = r_rdata;

endmodule

// File: tb/tb_ls_input_conditioner.sv
// Directed bench: stimulus pushes expected values tagged with a target cycle,
// and a monitor on the falling edge pops and compares them.
module tb_ls_input_conditioner;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [15:0] raw_in     = 16'h0000;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [31:0] readdata;
  logic [15:0] clean_out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t0;

  typedef struct {
    int          at;
    bit          is_rd;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  ls_input_conditioner #(
    .WIDTH(16), .CNT_W(16), .SYNC_STAGES(2), .DEF_DEBOUNCE(1000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .clean_out(clean_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every entry whose target cycle has arrived
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        act = sb[i].is_rd ? readdata : {16'h0000, clean_out};
        checks++;
        if ((sb[i].at != cyc) || ((act & sb[i].mask) !== (sb[i].val & sb[i].mask))) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h) cycle %0d target %0d",
                   sb[i].name, act & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask, cyc, sb[i].at);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input string name, input bit is_rd, input int at,
                      input logic [31:0] mask, input logic [31:0] val);
    exp_t e;
    e.at = at; e.is_rd = is_rd; e.mask = mask; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_cc;
`ifdef LS_COND_CHANGE_CNT_EN
    exp_cc = 32'h0003_0000;
`else
    exp_cc = 32'h0000_0000;
`endif
    // reset state
    push("rst_clean", 1'b0, 1, 32'h0000_FFFF, 32'h0);
    push("rst_rdata", 1'b1, 1, 32'hFFFF_FFFF, 32'h0);
    tick(3);
    reset_n = 1'b1;
    address = 2'd1;
    push("thr_default", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'd1000);
    tick(2);

    // debounced step latency with thr=4
    bus_write(2'd1, 32'd4);
    push("thr_rd4", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'd4);
    tick(2);
    t0 = cyc; raw_in[0] = 1'b1;
    push("step_before", 1'b0, t0 + 6, 32'h1, 32'h0);
    push("step_edge",   1'b0, t0 + 7, 32'h1, 32'h1);
    tick(10);

    // 3-cycle glitch rejected, 4-cycle pulse accepted both ways
    t0 = cyc; raw_in[3] = 1'b1;
    push("glitch3_a", 1'b0, t0 + 6,  32'h8, 32'h0);
    push("glitch3_b", 1'b0, t0 + 7,  32'h8, 32'h0);
    push("glitch3_c", 1'b0, t0 + 10, 32'h8, 32'h0);
    tick(3); raw_in[3] = 1'b0;
    tick(12);
    t0 = cyc; raw_in[3] = 1'b1;
    push("pulse4_pre",  1'b0, t0 + 6,  32'h8, 32'h0);
    push("pulse4_rise", 1'b0, t0 + 7,  32'h8, 32'h8);
    push("pulse4_hold", 1'b0, t0 + 10, 32'h8, 32'h8);
    push("pulse4_fall", 1'b0, t0 + 11, 32'h8, 32'h0);
    tick(4); raw_in[3] = 1'b0;
    tick(10);

    // invert and bypass masks
    raw_in[0] = 1'b0;
    tick(10);
    bus_write(2'd2, 32'h1);
    push("inv_apply", 1'b0, cyc + 1, 32'hFFFF, 32'h0001);
    bus_write(2'd3, 32'h2);
    push("byp_idle", 1'b0, cyc + 1, 32'hFFFF, 32'h0001);
    tick(2);
    t0 = cyc; raw_in[1] = 1'b1;
    push("byp_pre",   1'b0, t0 + 2, 32'hFFFF, 32'h0001);
    push("byp_pulse", 1'b0, t0 + 3, 32'hFFFF, 32'h0003);
    push("byp_post",  1'b0, t0 + 4, 32'hFFFF, 32'h0001);
    tick(1); raw_in[1] = 1'b0;
    tick(6);

    // lowering thr mid-count accepts on the next cycle
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'd100);
    tick(3);
    t0 = cyc; raw_in[2] = 1'b1;
    push("thr_low_pre", 1'b0, t0 + 12, 32'h4, 32'h0);
    push("thr_low_acc", 1'b0, t0 + 13, 32'h4, 32'h4);
    tick(10);
    bus_write(2'd1, 32'd5);
    tick(5);

    // thr=0 behaves as 1
    bus_write(2'd1, 32'd0);
    push("thr_rd0", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'd0);
    tick(2);
    t0 = cyc; raw_in[4] = 1'b1;
    push("thr0_pre",  1'b0, t0 + 3, 32'h10, 32'h0);
    push("thr0_edge", 1'b0, t0 + 4, 32'h10, 32'h10);
    tick(6);

    // readback and reset mid-count
    bus_write(2'd1, 32'h1234);
    push("thr_rd1234", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'h1234);
    tick(2);
    raw_in[5] = 1'b1;
    tick(5);
    reset_n = 1'b0;
    push("rst_mid_clean", 1'b0, cyc + 1, 32'hFFFF, 32'h0);
    push("rst_mid_rdata", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'h0);
    tick(3);
    reset_n = 1'b1;
    push("rst_mid_thr", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'd1000);
    tick(2);

    // change counter: three accepted edges, then clear
    bus_write(2'd1, 32'd1);
    tick(10);
    bus_write(2'd0, 32'h0);
    tick(2);
    raw_in[6] = 1'b1; tick(6);
    raw_in[6] = 1'b0; tick(6);
    raw_in[6] = 1'b1; tick(10);
    push("cc_three", 1'b1, cyc + 1, 32'hFFFF_FFFF, exp_cc | 32'h0000_0074);
    tick(2);
    bus_write(2'd0, 32'h0);
    push("cc_clear", 1'b1, cyc + 1, 32'hFFFF_FFFF, 32'h0000_0074);
    tick(2);

    // drain with a bound
    for (int k = 0; (k < 100) && (sb.size() > 0); k++) tick(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
